mlp_engine: RTL and testbench

- Parametrised successor of the fixed 784-32-10 MNIST accelerator top.
- Computes a two-layer fully-connected network (N_IN -> N_HID -> N_OUT) with ReLU and requantisation between the layers, plus an optional argmax stage.
- Pixels arrive on a valid/ready stream. Weights come from external asynchronous-read ROMs through address/data ports.
- Sits between the picoRV32 bus adapter (pixel stream, start/done) and the weight memory.

---
 rtl/mlp_pkg.sv | 44 ++++
 rtl/mlp_mac_lane.sv | 46 ++++
 rtl/mlp_engine.sv | 213 +++++++++++++++++++++
 tb/tb_mlp_engine.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared constants, FSM state encoding and the hidden-layer activation helper
// for the two-layer MLP engine.
package mlp_pkg;

  localparam int MLP_DW    = 8;
  localparam int MLP_ACC_W = 32;
  localparam int MLP_N_IN  = 784;
  localparam int MLP_N_HID = 32;
  localparam int MLP_N_OUT = 10;
  localparam int MLP_SHIFT = 8;

  // Working width of the activation helper; ACC_W must not exceed it.
  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_HIDDEN = 3'd2,
    ST_ARGMAX = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // ReLU, arithmetic shift, then clamp to the largest positive dw-bit value.
  function automatic logic signed [MAX_W-1:0] relu_shift_sat(
    input logic signed [MAX_W-1:0] sum,
    input int unsigned             shift,
    input int unsigned             dw
  );
    logic signed [MAX_W-1:0] shifted;
    logic signed [MAX_W-1:0] max_pos;
    logic signed [MAX_W-1:0] res;
    max_pos = (64'sd1 <<< (dw - 32'd1)) - 64'sd1;
    shifted = sum >>> shift;
    if (sum < 64'sd0) begin
      res = 64'sd0;
    end else if (shifted > max_pos) begin
      res = max_pos;
    end else begin
      res = shifted;
    end
    return res;
  endfunction

endpackage

// File: rtl/mlp_mac_lane.sv
// One signed DW x DW multiply-accumulate lane with synchronous clear and enable;
// the full-width product is sign-extended and accumulated modulo 2^ACC_W.
module mlp_mac_lane
  import mlp_pkg::*;
#(
  parameter int DW    = MLP_DW,
  parameter int ACC_W = MLP_ACC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [ACC_W-1:0] acc
);

  logic signed [2*DW-1:0] prod_s;
  logic [ACC_W-1:0]       acc_d;
  logic [ACC_W-1:0]       acc_q;

  // Next accumulator value: clear wins over enable.
  always_comb begin
    prod_s = $signed(a) * $signed(b);
    acc_d  = acc_q;
    if (clr) begin
      acc_d = {ACC_W{1'b0}};
    end else if (en) begin
      acc_d = acc_q + {{(ACC_W-2*DW){prod_s[2*DW-1]}}, prod_s};
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= {ACC_W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mlp_engine.sv
// Two-layer MLP engine (N_IN -> N_HID -> N_OUT) with ReLU/requantise between layers.
// Optional argmax stage enabled by defining MLP_ENGINE_ARGMAX_EN.
module mlp_engine
  import mlp_pkg::*;
#(
  parameter int DW    = MLP_DW,
  parameter int ACC_W = MLP_ACC_W,
  parameter int N_IN  = MLP_N_IN,
  parameter int N_HID = MLP_N_HID,
  parameter int N_OUT = MLP_N_OUT,
  parameter int SHIFT = MLP_SHIFT,
  localparam int IN_AW  = (N_IN  > 1) ? $clog2(N_IN)  : 1,
  localparam int HID_AW = (N_HID > 1) ? $clog2(N_HID) : 1,
  localparam int OUT_AW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  input  logic                   in_valid,
  input  logic [DW-1:0]          in_data,
  output logic                   in_ready,
  output logic [IN_AW-1:0]       w1_addr,
  input  logic [N_HID*DW-1:0]    w1_data,
  output logic [HID_AW-1:0]      w2_addr,
  input  logic [N_OUT*DW-1:0]    w2_data,
  output logic [N_OUT*ACC_W-1:0] scores,
  output logic [OUT_AW-1:0]      class_idx
);

  localparam int PIX_W = $clog2(N_IN + 1);
  localparam int H_W   = $clog2(((N_HID > N_OUT) ? N_HID : N_OUT) + 1);

  state_e           state_q, state_d;
  logic [PIX_W-1:0] cnt_q, cnt_d;
  logic [H_W-1:0]   h_q, h_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;

  logic             clr_s;
  logic             accept_s;
  logic             l2_en_s;
  logic [ACC_W-1:0] acc1 [N_HID];
  logic [ACC_W-1:0] acc2 [N_OUT];
  logic [ACC_W-1:0] acc1_sel_s;
  logic [MAX_W-1:0] r_full_s;
  logic [DW-1:0]    r_s;

`ifdef MLP_ENGINE_ARGMAX_EN
  logic [OUT_AW-1:0] best_idx_q, best_idx_d;
  logic [ACC_W-1:0]  best_val_q, best_val_d;
  logic [ACC_W-1:0]  score_sel_s;
`endif

  assign clr_s    = (state_q == ST_IDLE) && start;
  assign accept_s = (state_q == ST_LOAD) && in_valid && in_ready_q;
  assign l2_en_s  = (state_q == ST_HIDDEN);
  assign w1_addr  = cnt_q[IN_AW-1:0];
  assign w2_addr  = h_q[HID_AW-1:0];

  // Requantised activation of the hidden neuron currently addressed.
  always_comb begin
    acc1_sel_s = acc1[h_q[HID_AW-1:0]];
    r_full_s   = relu_shift_sat({{(MAX_W-ACC_W){acc1_sel_s[ACC_W-1]}}, acc1_sel_s},
                                SHIFT, DW);
    r_s        = r_full_s[DW-1:0];
  end

  for (genvar j = 0; j < N_HID; j++) begin : g_l1
    mlp_mac_lane #(.DW(DW), .ACC_W(ACC_W)) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_s),
      .en    (accept_s),
      .a     (in_data),
      .b     (w1_data[j*DW +: DW]),
      .acc   (acc1[j])
    );
  end

  for (genvar o = 0; o < N_OUT; o++) begin : g_l2
    mlp_mac_lane #(.DW(DW), .ACC_W(ACC_W)) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_s),
      .en    (l2_en_s),
      .a     (r_s),
      .b     (w2_data[o*DW +: DW]),
      .acc   (acc2[o])
    );
    assign scores[o*ACC_W +: ACC_W] = acc2[o];
  end

`ifdef MLP_ENGINE_ARGMAX_EN
  assign score_sel_s = acc2[h_q[OUT_AW-1:0]];
`endif

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
`ifdef MLP_ENGINE_ARGMAX_EN
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = {PIX_W{1'b0}};
          h_d     = {H_W{1'b0}};
`ifdef MLP_ENGINE_ARGMAX_EN
          best_idx_d = {OUT_AW{1'b0}};
          best_val_d = {ACC_W{1'b0}};
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          cnt_d = cnt_q + {{(PIX_W-1){1'b0}}, 1'b1};
          if (cnt_q == PIX_W'(N_IN - 1)) begin
            state_d = ST_HIDDEN;
            h_d     = {H_W{1'b0}};
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_HIDDEN: begin
        if (h_q == H_W'(N_HID - 1)) begin
          h_d = {H_W{1'b0}};
`ifdef MLP_ENGINE_ARGMAX_EN
          state_d = ST_ARGMAX;
`else
          state_d = ST_FINISH;
`endif
        end else begin
          h_d = h_q + {{(H_W-1){1'b0}}, 1'b1};
        end
      end
`ifdef MLP_ENGINE_ARGMAX_EN
      ST_ARGMAX: begin
        // Strictly-greater keeps the lowest index on ties.
        if ((h_q == {H_W{1'b0}}) || ($signed(score_sel_s) > $signed(best_val_q))) begin
          best_idx_d = h_q[OUT_AW-1:0];
          best_val_d = score_sel_s;
        end else begin
          best_idx_d = best_idx_q;
        end
        if (h_q == H_W'(N_OUT - 1)) begin
          state_d = ST_FINISH;
          h_d     = {H_W{1'b0}};
        end else begin
          h_d = h_q + {{(H_W-1){1'b0}}, 1'b1};
        end
      end
`endif
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    done_d     = (state_d == ST_FINISH);
    busy_d     = (state_d != ST_IDLE);
    in_ready_d = (state_d == ST_LOAD) && (cnt_d < PIX_W'(N_IN));
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {PIX_W{1'b0}};
      h_q        <= {H_W{1'b0}};
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
`ifdef MLP_ENGINE_ARGMAX_EN
      best_idx_q <= {OUT_AW{1'b0}};
      best_val_q <= {ACC_W{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      h_q        <= h_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
`ifdef MLP_ENGINE_ARGMAX_EN
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
`endif
    end
  end

  assign done     = done_q;
  assign busy     = busy_q;
  assign in_ready = in_ready_q;
`ifdef MLP_ENGINE_ARGMAX_EN
  assign class_idx = best_idx_q;
`else
  assign class_idx = {OUT_AW{1'b0}};
`endif

endmodule

// File: tb/tb_mlp_engine.sv
// Directed self-checking bench for mlp_engine in a 4-2-3 configuration, SHIFT=0.
module tb_mlp_engine;

  localparam int DW = 8, ACC_W = 32, N_IN = 4, N_HID = 2, N_OUT = 3, SHIFT = 0;
`ifdef MLP_ENGINE_ARGMAX_EN
  localparam int EXP_LAT = N_HID + N_OUT + 1;
  localparam bit ARGMAX_ON = 1'b1;
`else
  localparam int EXP_LAT = N_HID + 1;
  localparam bit ARGMAX_ON = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   start = 1'b0;
  logic                   busy, done, in_ready;
  logic                   in_valid = 1'b0;
  logic [DW-1:0]          in_data = 8'd0;
  logic [1:0]             w1_addr;
  logic [N_HID*DW-1:0]    w1_data;
  logic [0:0]             w2_addr;
  logic [N_OUT*DW-1:0]    w2_data;
  logic [N_OUT*ACC_W-1:0] scores;
  logic [1:0]             class_idx;

  logic [DW-1:0] w1_mem [N_IN][N_HID];
  logic [DW-1:0] w2_mem [N_HID][N_OUT];
  logic [DW-1:0] pix_mem [N_IN];

  int checks = 0;
  int failures = 0;

  mlp_engine #(.DW(DW), .ACC_W(ACC_W), .N_IN(N_IN), .N_HID(N_HID),
               .N_OUT(N_OUT), .SHIFT(SHIFT)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .w1_addr(w1_addr), .w1_data(w1_data), .w2_addr(w2_addr), .w2_data(w2_data),
    .scores(scores), .class_idx(class_idx)
  );

  always #5 clk = ~clk;

  // Asynchronous-read weight ROM models.
  always_comb begin
    for (int j = 0; j < N_HID; j++) w1_data[j*DW +: DW] = w1_mem[w1_addr][j];
    for (int o = 0; o < N_OUT; o++) w2_data[o*DW +: DW] = w2_mem[w2_addr][o];
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint score(input int o);
    return longint'($signed(scores[o*ACC_W +: ACC_W]));
  endfunction

  task automatic set_w(input logic [7:0] l0, input logic [7:0] l1,
                       input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                       input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    for (int i = 0; i < N_IN; i++) begin
      w1_mem[i][0] = l0;
      w1_mem[i][1] = l1;
    end
    w2_mem[0][0] = a0; w2_mem[0][1] = a1; w2_mem[0][2] = a2;
    w2_mem[1][0] = b0; w2_mem[1][1] = b1; w2_mem[1][2] = b2;
  endtask

  // Starts an inference, streams pix_mem (optionally with random stalls),
  // and checks latency, scores, class and the single done pulse.
  task automatic run_inf(input string tag, input bit stall, input bit start_in_hidden,
                         input longint e0, input longint e1, input longint e2,
                         input longint ecls);
    int i, guard, n, ndone;
    bit v;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "_in_ready"}, longint'(in_ready), 1);
    i = 0; guard = 0;
    while (i < N_IN && guard < 200) begin
      v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      in_data  = pix_mem[i];
      v = v && in_ready;
      @(negedge clk);
      if (v) i++;
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 200) check({tag, "_pix_timeout"}, 1, 0);
    n = 1; ndone = 0;
    while (!done && n < 40) begin
      start = (start_in_hidden && n == 1);
      @(negedge clk); n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, longint'(n), longint'(EXP_LAT));
    check({tag, "_score0"}, score(0), e0);
    check({tag, "_score1"}, score(1), e1);
    check({tag, "_score2"}, score(2), e2);
    check({tag, "_class"}, longint'(class_idx), ARGMAX_ON ? ecls : 0);
    for (int k = 0; k < 10; k++) begin
      if (done) ndone++;
      @(negedge clk);
      if (k == 0) check({tag, "_busy_after"}, longint'(busy), 0);
    end
    check({tag, "_extra_done"}, longint'(ndone), 1);
    check({tag, "_score_hold"}, score(2), e2);
  endtask

  initial begin
    set_w(8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3);
    for (int i = 0; i < N_IN; i++) pix_mem[i] = 8'(i + 1);
    repeat (3) @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_score0", score(0), 0);
    check("rst_class", longint'(class_idx), 0);
    reset = 1'b1;
    @(negedge clk);

    // acc1 = 10,10 -> scores 20,40,60
    run_inf("basic", 1'b0, 1'b0, 20, 40, 60, 2);

    // lane 0 weights -1: acc1 = -10 -> r0 = 0
    set_w(8'hFF, 8'd1, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3);
    run_inf("neg", 1'b0, 1'b0, 10, 20, 30, 2);

    // 4*127*127 = 64516 clamps to 127
    set_w(8'd127, 8'd127, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3);
    for (int i = 0; i < N_IN; i++) pix_mem[i] = 8'd127;
    run_inf("sat", 1'b0, 1'b0, 254, 508, 762, 2);

    set_w(8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3);
    for (int i = 0; i < N_IN; i++) pix_mem[i] = 8'(i + 1);
    run_inf("stall", 1'b1, 1'b0, 20, 40, 60, 2);

    // Reset in the middle of LOAD.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'd9;
    repeat (2) @(negedge clk);
    in_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", longint'(busy), 0);
    check("midrst_in_ready", longint'(in_ready), 0);
    check("midrst_score0", score(0), 0);
    check("midrst_score2", score(2), 0);
    reset = 1'b1;
    run_inf("after_rst", 1'b0, 1'b0, 20, 40, 60, 2);

    run_inf("start_hid", 1'b0, 1'b1, 20, 40, 60, 2);

    // acc1 = 1,1 -> scores 5,5,3, tie resolves to index 0
    set_w(8'd1, 8'd1, 8'd5, 8'd5, 8'd3, 8'd0, 8'd0, 8'd0);
    pix_mem[0] = 8'd1; pix_mem[1] = 8'd0; pix_mem[2] = 8'd0; pix_mem[3] = 8'd0;
    run_inf("tie", 1'b0, 1'b0, 5, 5, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
